// File: rtl/operand_forward_unit.sv
// ID/EX operand capture, priority forwarding and load-use stall control.
// Optional FWD_STATS_EN adds stall/forward event counters.
module operand_forward_unit #(
  parameter int XLEN           = 32,
  parameter int REG_AW         = 5,
  parameter int NUM_SRC        = 2,
  parameter int LOAD_FWD_STAGE = 2,
  parameter int SELW           = $clog2(NUM_SRC+1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    id_valid,
  output logic                    id_ready,
  input  logic [REG_AW-1:0]       id_rs1,
  input  logic [REG_AW-1:0]       id_rs2,
  input  logic [XLEN-1:0]         id_rs1_data,
  input  logic [XLEN-1:0]         id_rs2_data,
  input  logic [REG_AW-1:0]       id_rd,
  input  logic                    id_we,
  input  logic                    id_is_load,
  input  logic [NUM_SRC*XLEN-1:0] src_data,
  output logic                    ex_valid,
  output logic [XLEN-1:0]         op_a,
  output logic [XLEN-1:0]         op_b,
  output logic [SELW-1:0]         fwd_sel_a,
  output logic [SELW-1:0]         fwd_sel_b
`ifdef FWD_STATS_EN
  ,
  output logic [31:0]             stat_stall_cycles,
  output logic [31:0]             stat_fwd_a,
  output logic [31:0]             stat_fwd_b
`endif
);

  logic [NUM_SRC:0]  t_valid;
  logic [NUM_SRC:0]  t_we;
  logic [NUM_SRC:0]  t_ld;
  logic [REG_AW-1:0] t_rd [NUM_SRC:0];

  logic [REG_AW-1:0] cap_rs1;
  logic [REG_AW-1:0] cap_rs2;
  logic [XLEN-1:0]   cap_d1;
  logic [XLEN-1:0]   cap_d2;

  logic              hz;
  logic              issue;
  logic [NUM_SRC:1]  fwd_ok;

  always_comb begin
    hz = 1'b0;
    for (int j = 0; j < LOAD_FWD_STAGE-1; j++) begin
      if (id_valid && t_valid[j] && t_we[j] && t_ld[j] &&
          t_rd[j] != '0 &&
          (t_rd[j] == id_rs1 || t_rd[j] == id_rs2))
        hz = 1'b1;
    end
  end

  assign id_ready = !hz || flush;
  assign issue    = id_valid && id_ready && !flush;
  assign ex_valid = t_valid[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_valid <= '0;
      t_we    <= '0;
      t_ld    <= '0;
      for (int k = 0; k <= NUM_SRC; k++)
        t_rd[k] <= '0;
      cap_rs1 <= '0;
      cap_rs2 <= '0;
      cap_d1  <= '0;
      cap_d2  <= '0;
    end else begin
      for (int k = 1; k <= NUM_SRC; k++) begin
        t_valid[k] <= t_valid[k-1];
        t_we[k]    <= t_we[k-1];
        t_ld[k]    <= t_ld[k-1];
        t_rd[k]    <= t_rd[k-1];
      end
      t_valid[0] <= issue;
      if (issue) begin
        t_we[0]  <= id_we;
        t_ld[0]  <= id_is_load;
        t_rd[0]  <= id_rd;
        cap_rs1  <= id_rs1;
        cap_rs2  <= id_rs2;
        cap_d1   <= id_rs1_data;
        cap_d2   <= id_rs2_data;
      end
    end
  end

  // A load result only becomes usable from LOAD_FWD_STAGE onward.
  always_comb begin
    for (int k = 1; k <= NUM_SRC; k++)
      fwd_ok[k] = t_valid[k] && t_we[k] &&
                  (!t_ld[k] || k >= LOAD_FWD_STAGE);
  end

  // Scan oldest to youngest so the youngest match wins.
  always_comb begin
    fwd_sel_a = '0;
    fwd_sel_b = '0;
    op_a      = cap_d1;
    op_b      = cap_d2;
    for (int k = NUM_SRC; k >= 1; k--) begin
      if (fwd_ok[k] && cap_rs1 != '0 && t_rd[k] == cap_rs1) begin
        fwd_sel_a = SELW'(k);
        op_a      = src_data[(k-1)*XLEN +: XLEN];
      end
      if (fwd_ok[k] && cap_rs2 != '0 && t_rd[k] == cap_rs2) begin
        fwd_sel_b = SELW'(k);
        op_b      = src_data[(k-1)*XLEN +: XLEN];
      end
    end
  end

`ifdef FWD_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_stall_cycles <= '0;
      stat_fwd_a        <= '0;
      stat_fwd_b        <= '0;
    end else begin
      if (hz && !flush)
        stat_stall_cycles <= stat_stall_cycles + 32'd1;
      if (ex_valid && fwd_sel_a != '0)
        stat_fwd_a <= stat_fwd_a + 32'd1;
      if (ex_valid && fwd_sel_b != '0)
        stat_fwd_b <= stat_fwd_b + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_operand_forward_unit.sv
// Bench for operand_forward_unit: vector table, reset/stall sequences,
// and random traffic against an issue-age reference model.
module tb_operand_forward_unit;

  localparam int N   = 2;
  localparam int LFS = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [31:0] id_rs1_data, id_rs2_data;
  logic        id_we, id_is_load;
  logic [63:0] src_data;
  logic [95:0] src3;

  logic        id_ready, ex_valid;
  logic [31:0] op_a, op_b;
  logic [1:0]  sel_a, sel_b;

  logic        id_ready2, ex_valid2;
  logic [31:0] op_a2, op_b2;
  logic [1:0]  sel_a2, sel_b2;

`ifdef FWD_STATS_EN
  logic [31:0] st_stall, st_fa, st_fb;
  logic [31:0] st_stall2, st_fa2, st_fb2;
`endif

  always #5 clk = ~clk;

  operand_forward_unit dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_rd(id_rd), .id_we(id_we), .id_is_load(id_is_load),
    .src_data(src_data), .ex_valid(ex_valid),
    .op_a(op_a), .op_b(op_b),
    .fwd_sel_a(sel_a), .fwd_sel_b(sel_b)
`ifdef FWD_STATS_EN
    , .stat_stall_cycles(st_stall)
    , .stat_fwd_a(st_fa), .stat_fwd_b(st_fb)
`endif
  );

  operand_forward_unit #(.NUM_SRC(3), .LOAD_FWD_STAGE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .id_valid(id_valid), .id_ready(id_ready2),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_rd(id_rd), .id_we(id_we), .id_is_load(id_is_load),
    .src_data(src3), .ex_valid(ex_valid2),
    .op_a(op_a2), .op_b(op_b2),
    .fwd_sel_a(sel_a2), .fwd_sel_b(sel_b2)
`ifdef FWD_STATS_EN
    , .stat_stall_cycles(st_stall2)
    , .stat_fwd_a(st_fa2), .stat_fwd_b(st_fb2)
`endif
  );

  int checks = 0;
  int passes = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic drive(input logic fl, input logic vl,
                       input logic [4:0] r1, input logic [4:0] r2,
                       input logic [31:0] d1, input logic [31:0] d2,
                       input logic [4:0] rd, input logic we,
                       input logic ld);
    flush = fl; id_valid = vl;
    id_rs1 = r1; id_rs2 = r2;
    id_rs1_data = d1; id_rs2_data = d2;
    id_rd = rd; id_we = we; id_is_load = ld;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic fl, vl;
    logic [4:0] r1, r2;
    logic [31:0] d1, d2;
    logic [4:0] rd;
    logic we, ld;
    logic [31:0] s1, s2;
    logic rdy, exv;
    logic [1:0] sa, sb;
    logic [31:0] oa, ob;
  } vec_t;

  vec_t tbl [14];

  // Reference model: in-flight instructions keyed by issue time.
  typedef struct {
    logic [4:0] rd;
    logic we, ld;
    int ts;
  } rec_t;

  rec_t q[$];
  int now;
  logic [4:0]  m_rs1, m_rs2;
  logic [31:0] m_d1, m_d2;
  logic [31:0] m_stall, m_fa, m_fb;

  task automatic model_reset();
    q.delete();
    now = 0;
    m_rs1 = '0; m_rs2 = '0; m_d1 = '0; m_d2 = '0;
    m_stall = '0; m_fa = '0; m_fb = '0;
  endtask

  function automatic void resolve(input logic [4:0] rs,
                                  input logic [31:0] cap,
                                  output logic [31:0] op,
                                  output logic [1:0] sel);
    int best = 99;
    op = cap; sel = '0;
    if (rs == 0) return;
    foreach (q[i]) begin
      int age = now - q[i].ts;
      if (age >= 1 && age <= N && q[i].we && q[i].rd == rs &&
          !(q[i].ld && age < LFS) && age < best)
        best = age;
    end
    if (best != 99) begin
      op  = src_data[(best-1)*32 +: 32];
      sel = 2'(best);
    end
  endfunction

  task automatic rand_cycle(input int n);
    logic hz, exv, rdy;
    logic [31:0] ea, eb;
    logic [1:0] sa, sb;
    drive($urandom_range(0, 99) < 8, $urandom_range(0, 99) < 80,
          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
          $urandom, $urandom, 5'($urandom_range(0, 3)),
          $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 35);
    src_data = {$urandom, $urandom};
    #4;
    hz = 1'b0; exv = 1'b0;
    foreach (q[i]) begin
      int age = now - q[i].ts;
      if (age == 0) exv = 1'b1;
      if (id_valid && age < LFS-1 && q[i].we && q[i].ld &&
          q[i].rd != 0 && (q[i].rd == id_rs1 || q[i].rd == id_rs2))
        hz = 1'b1;
    end
    rdy = !hz || flush;
    resolve(m_rs1, m_d1, ea, sa);
    resolve(m_rs2, m_d2, eb, sb);
    chk($sformatf("rnd%0d id_ready", n), 32'(id_ready), 32'(rdy));
    chk($sformatf("rnd%0d ex_valid", n), 32'(ex_valid), 32'(exv));
    chk($sformatf("rnd%0d op_a", n), op_a, ea);
    chk($sformatf("rnd%0d op_b", n), op_b, eb);
    chk($sformatf("rnd%0d sel_a", n), 32'(sel_a), 32'(sa));
    chk($sformatf("rnd%0d sel_b", n), 32'(sel_b), 32'(sb));
`ifdef FWD_STATS_EN
    chk($sformatf("rnd%0d stat_stall", n), st_stall, m_stall);
    chk($sformatf("rnd%0d stat_fwd_a", n), st_fa, m_fa);
    chk($sformatf("rnd%0d stat_fwd_b", n), st_fb, m_fb);
`endif
    @(posedge clk);
    if (hz && !flush) m_stall++;
    if (exv && sa != 0) m_fa++;
    if (exv && sb != 0) m_fb++;
    now++;
    if (id_valid && rdy && !flush) begin
      q.push_back('{id_rd, id_we, id_is_load, now});
      m_rs1 = id_rs1; m_rs2 = id_rs2;
      m_d1 = id_rs1_data; m_d2 = id_rs2_data;
    end
    while (q.size() > 0 && now - q[0].ts > N) void'(q.pop_front());
    #1;
  endtask

  initial begin
    tbl[0]  = '{0,1'b0, 0,0, 0,0, 0,0,0, 0,0,
                1,0, 0,0, 0,0};
    tbl[1]  = '{0,1, 1,2, 'h11,'h22, 5,1,0, 0,0,
                1,0, 0,0, 0,0};
    tbl[2]  = '{0,1, 5,0, 'h55,'h99, 5,1,0, 'h1234,0,
                1,1, 0,0, 'h11,'h22};
    tbl[3]  = '{0,1, 5,1, 0,'h33, 0,0,0, 'h1234,'h7777,
                1,1, 1,0, 'h1234,'h99};
    tbl[4]  = '{0,1, 3,0, 3,0, 7,1,1, 'hAAAA,'hBBBB,
                1,1, 1,0, 'hAAAA,'h33};
    tbl[5]  = '{0,1, 0,7, 0,1, 8,1,0, 0,0,
                0,1, 0,0, 3,0};
    tbl[6]  = '{0,1, 0,7, 0,1, 8,1,0, 0,0,
                1,0, 0,0, 3,0};
    tbl[7]  = '{0,1, 0,0, 0,0, 0,1,0, 'h1111,'hCAFE,
                1,1, 0,2, 0,'hCAFE};
    tbl[8]  = '{0,1, 0,0, 'h5A,'h6B, 9,0,0, 'hDEAD,0,
                1,1, 0,0, 0,0};
    tbl[9]  = '{0,1, 0,0, 0,0, 10,1,1, 'hDEAD,'hBEEF,
                1,1, 0,0, 'h5A,'h6B};
    tbl[10] = '{1,1, 10,0, 1,2, 11,1,0, 0,0,
                1,1, 0,0, 0,0};
    tbl[11] = '{0,0, 0,0, 0,0, 0,0,0, 0,0,
                1,0, 0,0, 0,0};
    tbl[12] = '{0,1, 10,10, 'hF,'hF, 0,0,0, 0,0,
                1,0, 0,0, 0,0};
    tbl[13] = '{0,0, 0,0, 0,0, 0,0,0, 1,2,
                1,1, 0,0, 'hF,'hF};

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    src_data = '0;
    src3 = '0;
    step();
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].fl, tbl[i].vl, tbl[i].r1, tbl[i].r2,
            tbl[i].d1, tbl[i].d2, tbl[i].rd, tbl[i].we, tbl[i].ld);
      src_data = {tbl[i].s2, tbl[i].s1};
      #4;
      chk($sformatf("row%0d id_ready", i), 32'(id_ready), 32'(tbl[i].rdy));
      chk($sformatf("row%0d ex_valid", i), 32'(ex_valid), 32'(tbl[i].exv));
      chk($sformatf("row%0d sel_a", i), 32'(sel_a), 32'(tbl[i].sa));
      chk($sformatf("row%0d sel_b", i), 32'(sel_b), 32'(tbl[i].sb));
      chk($sformatf("row%0d op_a", i), op_a, tbl[i].oa);
      chk($sformatf("row%0d op_b", i), op_b, tbl[i].ob);
      step();
    end

    // Reset mid-stream with a stalled consumer in ID.
    drive(0, 1, 1, 2, 'h1, 'h2, 12, 1, 1);
    step();
    drive(0, 1, 1, 2, 'h3, 'h4, 13, 1, 0);
    step();
    drive(0, 1, 3, 4, 'h5, 'h6, 14, 1, 1);
    step();
    drive(0, 1, 14, 0, 'h7, 'h8, 15, 1, 0);
    #1;
    chk("pre-reset id_ready", 32'(id_ready), 32'd0);
    chk("pre-reset ex_valid", 32'(ex_valid), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async reset ex_valid", 32'(ex_valid), 32'd0);
    chk("async reset op_a", op_a, 32'd0);
    chk("async reset op_b", op_b, 32'd0);
    chk("async reset id_ready", 32'(id_ready), 32'd1);
    chk("async reset sel_a", 32'(sel_a), 32'd0);

    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    model_reset();
    rst_n = 1'b1;
    for (int n = 0; n < 400; n++) rand_cycle(n);

    // Deep pipeline: load result usable only from stage 3.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    drive(0, 1, 0, 0, 0, 0, 9, 1, 1);
    #4;
    chk("deep lw id_ready", 32'(id_ready2), 32'd1);
    step();
    drive(0, 1, 9, 0, 'h1, 'h2, 0, 0, 0);
    #4;
    chk("deep stall1 id_ready", 32'(id_ready2), 32'd0);
    step();
    #4;
    chk("deep stall2 id_ready", 32'(id_ready2), 32'd0);
    chk("deep stall2 ex_valid", 32'(ex_valid2), 32'd0);
    step();
    #4;
    chk("deep release id_ready", 32'(id_ready2), 32'd1);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    src3 = {32'h9999, 32'h2222, 32'h1111};
    #4;
    chk("deep ex_valid", 32'(ex_valid2), 32'd1);
    chk("deep sel_a", 32'(sel_a2), 32'd3);
    chk("deep op_a", op_a2, 32'h9999);
    chk("deep op_b", op_b2, 32'h2);
`ifdef FWD_STATS_EN
    chk("deep stat_stall", st_stall2, 32'd2);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/operand_forward_unit.md
Name: operand_forward_unit

Overview:
- Parametrised forwarding and load-use hazard controller for the ID/EX boundary of the pipelined core.
- Captures ID-stage register-file operands into an internal ID/EX operand register.
- Tracks destination tags of in-flight instructions in a NUM_SRC-deep shift register.
- In EX, drives operands resolved by priority forwarding, and stalls ID when a load result is not yet forwardable.

Parameters:
- XLEN, 32, operand/data width.
- REG_AW, 5, register address width; register 0 is hardwired zero.
- NUM_SRC, 2, number of forwarding source stages (1 = EX/MEM, 2 = MEM/WB, ...); range 1..6.
- LOAD_FWD_STAGE, 2, lowest stage index whose result is valid for a load; range 1..NUM_SRC.
- SELW, $clog2(NUM_SRC+1), width of the select outputs.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  kill the instruction entering EX and clear any stall.
- id_valid  in  1  ID holds a valid instruction.
- id_ready  out  1  ID instruction is accepted into EX this cycle.
- id_rs1, id_rs2  in  REG_AW  ID source register addresses.
- id_rs1_data, id_rs2_data  in  XLEN  register-file read data; the register file is write-first.
- id_rd  in  REG_AW  ID destination register.
- id_we  in  1  ID instruction writes rd.
- id_is_load  in  1  ID instruction is a load.
- src_data  in  NUM_SRC*XLEN  result data; slice [k*XLEN +: XLEN] is stage k+1.
- ex_valid  out  1  EX holds a valid, non-bubble instruction.
- op_a, op_b  out  XLEN  resolved EX operands.
- fwd_sel_a, fwd_sel_b  out  SELW  0 = captured register-file data, k = forwarded from stage k.

Behaviour:
- State:
  - Tag entries T[0..NUM_SRC], each holding {valid, we, is_load, rd}. T[0] is EX; T[k] is source stage k.
  - Captured rs1/rs2 addresses and data for the EX instruction.
- Reset (asynchronous, rst_n low):
  - All tag valid bits 0; captured addresses and data 0.
  - Outputs settle to: ex_valid=0, op_a=op_b=0, fwd_sel_a=fwd_sel_b=0, id_ready=1.
- Pipeline advance: every cycle T[k] <= T[k-1] for k=1..NUM_SRC. The back end never stalls, and T[NUM_SRC] retires.
- Load-use hazard (combinational):
  - hz is asserted when id_valid=1 and, for some j < LOAD_FWD_STAGE-1, all of the following hold:
    - T[j].valid, T[j].we and T[j].is_load are set;
    - T[j].rd != 0;
    - T[j].rd equals id_rs1 or id_rs2.
  - id_ready = !hz || flush.
- Issue:
  - Condition: id_valid && id_ready && !flush.
  - Effect: T[0] <= {1, id_we, id_is_load, id_rd}; capture rs addresses and data.
  - Otherwise T[0].valid <= 0 (bubble). Captured data is held.
- Stalling:
  - A stall lasts until the offending load shifts to an index >= LOAD_FWD_STAGE-1.
  - That gives LOAD_FWD_STAGE-1-j stall cycles; the default is 1 cycle.
  - No counter is needed: hz is re-evaluated every cycle from the shifting tags.
- Flush: takes priority over hz. A bubble is inserted, id_ready=1, and the ID instruction is dropped (upstream discards it).
- Forwarding (combinational in EX, per operand):
  - Candidate stage k in 1..NUM_SRC qualifies when:
    - T[k].valid, T[k].we set and T[k].rd == captured rs != 0;
    - and (!T[k].is_load || k >= LOAD_FWD_STAGE).
  - The lowest qualifying k wins (youngest result). The output then equals slice k-1 of src_data and fwd_sel equals k.
  - With no qualifying stage: captured data, sel=0.
  - Captured rs == 0 always yields the captured data, even if nonzero is presented.
- ex_valid = T[0].valid.
- Latency: one cycle from ID acceptance to EX operands valid.

Optional Feature:
- Macro: FWD_STATS_EN.
- When defined, adds three outputs, each 32-bit:
  - stat_stall_cycles: increments each cycle hz && !flush.
  - stat_fwd_a: increments each cycle ex_valid && fwd_sel_a != 0.
  - stat_fwd_b: increments each cycle ex_valid && fwd_sel_b != 0.
- Counter rules:
  - All three are reset to 0 by rst_n.
  - They wrap from 0xFFFFFFFF to 0.
  - They are not cleared by flush.
- When undefined, these ports and their registers are absent; the remaining behaviour is identical.

Test Plan:
- Reset mid-stream: assert rst_n=0 while 3 instructions are in flight -> ex_valid=0, op_a=0, id_ready=1 immediately, with no clock edge required.
- ALU back-to-back: issue add x5 (we), then add with rs1=x5; drive src_data stage1=0x1234 -> fwd_sel_a=1, op_a=0x1234.
- Double hazard priority: x5 written at stage 1 (0xAAAA) and stage 2 (0xBBBB) -> op_a=0xAAAA, fwd_sel_a=1.
- Load-use, default params: lw x7, then add rs2=x7 ->
  - id_ready=0 for exactly 1 cycle and ex_valid=0 in the bubble cycle;
  - then fwd_sel_b=2, op_b=stage2 data 0xCAFE.
- x0 and flush:
  - Writer with rd=0 and consumer with rs1=0 -> fwd_sel_a=0, no stall.
  - Load-use hazard with flush=1 in the same cycle -> id_ready=1, next ex_valid=0.
- NUM_SRC=3, LOAD_FWD_STAGE=3: lw x9 then dependent -> 2 stall cycles, then forward from stage 3. With FWD_STATS_EN defined: stat_stall_cycles=2.
